ps2_host_tx: RTL

- PS/2 host-to-device transmitter; companion to the keyboard receive path that shares the same ps2c/ps2d lines.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard:
  - requests to send by inhibiting the clock;
  - shifts 8 data bits, odd parity and stop on device-generated clock edges;
  - checks the device ACK.
- Drives the open-drain pads through active-high pull-low enables; the top level builds the tristate buffers.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte (for example 0xED set-LEDs or 0xFF reset) to a PS/2 device:
// it inhibits the clock line to request to send, drives the start bit, then
// shifts 8 data bits (LSB first), odd parity and the stop bit on the falling
// edges of the device-generated clock, and finally checks the device ACK.
// The pads are open-drain: this block only produces active-high pull-low
// enables and the top level builds the tristate buffers.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   defined   - a 20-bit watchdog counts every cycle outside IDLE; reaching
//               TIMEOUT_CYCLES releases both lines, pulses tx_err and
//               returns to IDLE.
//   undefined - no watchdog is built and the FSM waits for device edges
//               indefinitely.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles ps2c is held low before the start bit (>= 2)
//   FILTER_LEN      equal samples required to change a filtered line (>= 2)
//   TIMEOUT_CYCLES  watchdog limit per frame (watchdog build only)
//
// Ports:
//   clk, rst_n         system clock (posedge), asynchronous active-low reset
//   tx_data, tx_start  byte to send and request (accepted only in IDLE)
//   tx_busy            high from the cycle after acceptance until IDLE
//   tx_done, tx_err    one-cycle completion pulses (ACK seen / no ACK or timeout)
//   ps2c_in, ps2d_in   raw pad levels
//   ps2c_oe, ps2d_oe   1 = pull the line low, 0 = release

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int CNT_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Input conditioning: 2-flop synchronizer followed by an all-equal filter
  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] c_sh_q, d_sh_q;
  logic                  c_f_q, d_f_q, c_f_prev_q;
  logic                  fall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_q   <= '1;
      d_sync_q   <= '1;
      c_sh_q     <= '1;
      d_sh_q     <= '1;
      c_f_q      <= 1'b1;
      d_f_q      <= 1'b1;
      c_f_prev_q <= 1'b1;
    end else begin
      c_sync_q   <= {c_sync_q[0], ps2c_in};
      d_sync_q   <= {d_sync_q[0], ps2d_in};
      c_sh_q     <= {c_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
      d_sh_q     <= {d_sh_q[FILTER_LEN-2:0], d_sync_q[1]};
      // Level changes only when the whole window agrees; otherwise it holds
      if (&c_sh_q)       c_f_q <= 1'b1;
      else if (~|c_sh_q) c_f_q <= 1'b0;
      if (&d_sh_q)       d_f_q <= 1'b1;
      else if (~|d_sh_q) d_f_q <= 1'b0;
      c_f_prev_q <= c_f_q;
    end
  end

  assign fall_c = c_f_prev_q & ~c_f_q;

  // Transmit FSM with registered outputs
  state_t           state_q;
  logic             busy_q, done_q, err_q;
  logic             c_oe_q, d_oe_q;
  logic [8:0]       sh_q;      // {parity, data}; 1s shift in to form the stop bit
  logic [3:0]       n_q;       // falling-edge counter, stops at 11
  logic [CNT_W-1:0] cnt_q;     // inhibit duration counter
  logic             ack_ok_q;
`ifdef PS2_TX_TIMEOUT_EN
  logic [19:0]      wd_q;
`else
  logic             unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      sh_q     <= '1;
      n_q      <= '0;
      cnt_q    <= '0;
      ack_ok_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          c_oe_q <= 1'b0;
          d_oe_q <= 1'b0;
          if (tx_start) begin
            sh_q    <= {~^tx_data, tx_data};
            n_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            c_oe_q  <= 1'b1;
            state_q <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Start bit appears during the final inhibit cycle
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) d_oe_q <= 1'b1;
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            c_oe_q  <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          c_oe_q  <= 1'b0;
          d_oe_q  <= 1'b1;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fall_c) begin
            if (n_q == 4'd10) begin
              // 11th edge: device is holding its ACK on the data line
              n_q      <= 4'd11;
              ack_ok_q <= ~d_f_q;
              state_q  <= S_ACK;
            end else begin
              n_q    <= n_q + 4'd1;
              d_oe_q <= ~sh_q[0];
              sh_q   <= {1'b1, sh_q[8:1]};
            end
          end
        end
        S_ACK: begin
          state_q <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (c_f_q && d_f_q) begin
            done_q  <= ack_ok_q;
            err_q   <= ~ack_ok_q;
            busy_q  <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          c_oe_q  <= 1'b0;
          d_oe_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides whatever the state logic decided this cycle
      if (state_q == S_IDLE) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 20'd1;
        if (wd_q == 20'(TIMEOUT_CYCLES - 1)) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b1;
          c_oe_q  <= 1'b0;
          d_oe_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      end
`endif
    end
  end

  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;
  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;

endmodule
